// File: rtl/tt_um_nithin574.sv
// tt_um_nithin574: 8-bit programmable timer/counter tile.
// Prescaled up / down / up-down counting, PWM compare against a duty
// register, and a sticky terminal-count flag. Configured by opcode +
// strobe on uio_in; counter or status is read back on uo_out.
module tt_um_nithin574 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [2:0] OP_LOAD_CNT   = 3'b001;
  localparam logic [2:0] OP_LOAD_DUTY  = 3'b010;
  localparam logic [2:0] OP_LOAD_PRESC = 3'b011;
  localparam logic [2:0] OP_SET_MODE   = 3'b100;
  localparam logic [2:0] OP_CLR_FLAG   = 3'b101;

  localparam logic [1:0] MODE_STOP = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_UPDN = 2'b11;

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] duty_q, duty_d;
  logic [7:0] presc_q, presc_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic [1:0] mode_q, mode_d;
  logic       dir_q, dir_d;
  logic       flag_q, flag_d;

  logic       tick;
  logic       flag_set;
  logic       pwm;
  logic       strobe;
  logic [2:0] opcode;

  assign strobe = uio_in[3];
  assign opcode = uio_in[2:0];

  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in[6:4]};

  // Next-state: prescaler/tick step first, then the strobed command overrides
  // the fields it owns (a flag set by the tick outranks CLR_FLAG).
  always_comb begin
    cnt_d    = cnt_q;
    duty_d   = duty_q;
    presc_d  = presc_q;
    pcnt_d   = pcnt_q;
    mode_d   = mode_q;
    dir_d    = dir_q;
    flag_d   = flag_q;
    tick     = 1'b0;
    flag_set = 1'b0;
    if (ena) begin
      if (mode_q != MODE_STOP) begin
        if (pcnt_q == presc_q) begin
          tick   = 1'b1;
          pcnt_d = '0;
        end else begin
          pcnt_d = pcnt_q + 8'd1;
        end
      end
      if (tick) begin
        case (mode_q)
          MODE_UP: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'hFF) flag_set = 1'b1;
          end
          MODE_DOWN: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'h00) flag_set = 1'b1;
          end
          MODE_UPDN: begin
            if (dir_q) begin
              if (cnt_q == 8'hFF) begin
                cnt_d    = 8'hFE;
                dir_d    = 1'b0;
                flag_set = 1'b1;
              end else begin
                cnt_d = cnt_q + 8'd1;
              end
            end else begin
              if (cnt_q == 8'h00) begin
                cnt_d    = 8'h01;
                dir_d    = 1'b1;
                flag_set = 1'b1;
              end else begin
                cnt_d = cnt_q - 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
      if (flag_set) flag_d = 1'b1;
      if (strobe) begin
        case (opcode)
          OP_LOAD_CNT:   cnt_d = ui_in;
          OP_LOAD_DUTY:  duty_d = ui_in;
          OP_LOAD_PRESC: begin
            presc_d = ui_in;
            pcnt_d  = '0;
          end
          OP_SET_MODE: begin
            mode_d = ui_in[1:0];
            pcnt_d = '0;
            dir_d  = (ui_in[1:0] != MODE_DOWN);
          end
          OP_CLR_FLAG: begin
            if (!flag_set) flag_d = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      duty_q  <= '0;
      presc_q <= '0;
      pcnt_q  <= '0;
      mode_q  <= MODE_STOP;
      dir_q   <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      flag_q  <= flag_d;
    end
  end

  // Readback mux: counter value or packed status word.
  always_comb begin
    pwm     = (cnt_q < duty_q);
    uio_out = '0;
    uio_oe  = '0;
    if (uio_in[7]) uo_out = {pwm, flag_q, dir_q, 3'b000, mode_q};
    else           uo_out = cnt_q;
  end

endmodule

// File: tb/tb_tt_um_nithin574.sv
// Bench for tt_um_nithin574: directed scenarios then randomized commands,
// all compared against an integer reference model of the timer.
module tb_tt_um_nithin574;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks;
  int failures;

  // reference model state
  int m_cnt, m_duty, m_presc, m_pcnt, m_mode, m_dir, m_flag;

  tt_um_nithin574 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_duty = 0; m_presc = 0; m_pcnt = 0;
    m_mode = 0; m_dir = 0; m_flag = 0;
  endtask

  function automatic logic [7:0] model_status();
    int s;
    s = ((m_cnt < m_duty) ? 128 : 0) + m_flag * 64 + m_dir * 32 + m_mode;
    return s[7:0];
  endfunction

  // One rising edge of the timer, from the rules: tick step, then command.
  task automatic model_edge(input logic e, input logic [7:0] ctl, input logic [7:0] d);
    int  op;
    int  wrapped;
    bit  t;
    if (!e) return;
    t = 0;
    wrapped = 0;
    if (m_mode != 0) begin
      if (m_pcnt == m_presc) begin t = 1; m_pcnt = 0; end
      else m_pcnt = m_pcnt + 1;
    end
    if (t) begin
      if (m_mode == 1) begin
        wrapped = (m_cnt == 255);
        m_cnt = (m_cnt + 1) % 256;
      end else if (m_mode == 2) begin
        wrapped = (m_cnt == 0);
        m_cnt = (m_cnt + 255) % 256;
      end else if (m_dir == 1) begin
        if (m_cnt == 255) begin m_cnt = 254; m_dir = 0; wrapped = 1; end
        else m_cnt = m_cnt + 1;
      end else begin
        if (m_cnt == 0) begin m_cnt = 1; m_dir = 1; wrapped = 1; end
        else m_cnt = m_cnt - 1;
      end
    end
    if (wrapped) m_flag = 1;
    if (ctl[3]) begin
      op = int'(ctl[2:0]);
      case (op)
        1: m_cnt = d;
        2: m_duty = d;
        3: begin m_presc = d; m_pcnt = 0; end
        4: begin m_mode = d % 4; m_pcnt = 0; m_dir = (m_mode == 2) ? 0 : 1; end
        5: if (!wrapped) m_flag = 0;
        default: ;
      endcase
    end
  endtask

  // Compare both readback views, the constant uio outputs, then restore select.
  task automatic check_outputs(input string tag);
    logic sel;
    sel = uio_in[7];
    uio_in[7] = 1'b0;
    #1;
    check({tag, "_cnt"}, uo_out, m_cnt[7:0]);
    uio_in[7] = 1'b1;
    #1;
    check({tag, "_status"}, uo_out, model_status());
    uio_in[7] = sel;
  endtask

  // Apply inputs (already stable since the falling edge), clock once, check.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge(ena, uio_in, ui_in);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic cmd(input logic [2:0] op, input logic [7:0] d, input string tag);
    uio_in = {5'b00001, op};
    ui_in  = d;
    step(tag);
    uio_in = 8'h00;
    ui_in  = 8'h00;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    ena = 1'b1;
    rst_n = 1'b0;
    ui_in = 8'($urandom);
    uio_in = 8'($urandom);
    model_reset();
    #3;
    uio_in[7] = 1'b0;
    #1;
    check("reset_cnt", uo_out, 8'h00);
    uio_in[7] = 1'b1;
    #1;
    check("reset_status", uo_out, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    uio_in = 8'h00;
    ui_in = 8'h00;
    @(negedge clk);

    // up count through wrap
    cmd(3'b001, 8'hFE, "load_fe");
    cmd(3'b100, 8'h01, "mode_up");
    step("up1");
    check("up_ff", m_cnt[7:0], 8'hFF);
    step("up2");
    uio_in[7] = 1'b1; #1;
    check("up_wrap_status", uo_out, 8'h61);
    uio_in[7] = 1'b0;
    cmd(3'b101, 8'h00, "clr_flag");
    uio_in[7] = 1'b1; #1;
    check("clr_status", uo_out, 8'h21);
    uio_in[7] = 1'b0;

    // prescaler: one tick per 4 clocks
    cmd(3'b011, 8'd3, "presc3");
    cmd(3'b001, 8'h00, "load0");
    cmd(3'b100, 8'h01, "mode_up_p");
    for (int i = 0; i < 12; i++) step("presc_run");
    uio_in[7] = 1'b0; #1;
    check("presc_after12", uo_out, 8'h03);

    // up/down bounce at both ends
    cmd(3'b011, 8'd0, "presc0");
    cmd(3'b001, 8'hFE, "load_fe_ud");
    cmd(3'b100, 8'h03, "mode_ud");
    for (int i = 0; i < 4; i++) step("ud_top");
    cmd(3'b001, 8'h01, "load1_ud");
    for (int i = 0; i < 3; i++) step("ud_bottom");

    // PWM sweep with duty 0x80, then duty 0
    cmd(3'b010, 8'h80, "duty80");
    cmd(3'b100, 8'h01, "mode_up_pwm");
    for (int i = 0; i < 260; i++) step("pwm80");
    cmd(3'b010, 8'h00, "duty0");
    for (int i = 0; i < 20; i++) step("pwm0");

    // CLR_FLAG on a wrapping edge: set wins
    cmd(3'b001, 8'hFE, "load_fe_cf");
    step("pre_wrap");
    cmd(3'b101, 8'h00, "clr_on_wrap");

    // ena=0 freezes everything including a strobed load
    ena = 1'b0;
    for (int i = 0; i < 5; i++) cmd(3'b001, 8'h55, "ena0_load");
    ena = 1'b1;
    for (int i = 0; i < 3; i++) step("ena_resume");

    // async reset pulse mid-count, no clock edge needed
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    step("after_rst");

    // randomized command stream
    for (int i = 0; i < 3000; i++) begin
      ena = ($urandom_range(0, 9) != 0);
      ui_in = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        uio_in = {1'b0, 3'($urandom), 1'b1, 3'($urandom)};
        if (uio_in[2:0] == 3'b011) ui_in = 8'($urandom_range(0, 4));
      end else begin
        uio_in = {1'b0, 3'($urandom), 1'b0, 3'($urandom)};
      end
      uio_in[7] = 1'($urandom);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
